// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// Shared widths and types for the register-file write arbiter and its MDU result FIFO.
package rf_write_arbiter_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_DRAIN  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     data;
  } mdu_entry_t;

endpackage
`default_nettype wire

// File: rtl/mdu_result_fifo.sv
`default_nettype none
// MDU result FIFO with per-entry valid bits and kill-by-rd invalidation.
// WB_ARB_STATS_EN adds the kill_hits output (entries invalidated this cycle).
module mdu_result_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  mdu_entry_t                push_entry,
  input  logic                      pop,
  input  logic                      kill,
  input  logic [REG_ADDR_WIDTH-1:0] kill_rd,
  output logic                      empty,
  output logic                      full,
  output logic                      head_valid,
  output mdu_entry_t                head_entry,
  output logic                      live_after
`ifdef WB_ARB_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]    kill_hits
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  mdu_entry_t       mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] valid_next;
  logic [DEPTH-1:0] kill_mask;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             do_push;
  logic             do_pop;

  assign wr_idx     = wr_ptr[IDX_W-1:0];
  assign rd_idx     = rd_ptr[IDX_W-1:0];
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_idx == rd_idx);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign head_valid = valid[rd_idx];
  assign head_entry = mem[rd_idx];

  // Valid bits are only ever set on occupied slots, so kill needs no occupancy check.
  always_comb begin
    kill_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_mask[i] = kill && valid[i] && (mem[i].rd == kill_rd);
    end
  end

  always_comb begin
    valid_next = valid & ~kill_mask;
    if (do_pop) valid_next[rd_idx] = 1'b0;
    if (do_push) valid_next[wr_idx] = 1'b1;
  end

  assign live_after = |valid_next;

`ifdef WB_ARB_STATS_EN
  always_comb begin
    kill_hits = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_hits = kill_hits + PTR_W'(kill_mask[i]);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      valid  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      valid <= valid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= push_entry;
  end

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// Register-file write-port arbiter between the WB stage and buffered MDU results.
// WB_ARB_STATS_EN adds stall_cnt_o and kill_cnt_o statistics outputs.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wb_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic [DATA_WIDTH-1:0]     wb_data_i,
  input  logic                      mdu_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] mdu_rd_i,
  input  logic [DATA_WIDTH-1:0]     mdu_data_i,
  output logic                      mdu_ready_o,
  output logic                      wb_stall_o,
  output logic                      rf_we_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0]     rf_wdata_o
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               kill_cnt_o
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  arb_state_e        state;
  arb_state_e        state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;

  logic       draining;
  logic       wb_grant;
  logic       mdu_push;
  logic       bypass;
  logic       fifo_push;
  logic       fifo_pop;
  logic       head_write;
  logic       fifo_empty;
  logic       fifo_full;
  logic       head_valid;
  logic       live_after;
  mdu_entry_t mdu_entry;
  mdu_entry_t head_entry;
`ifdef WB_ARB_STATS_EN
  logic [$clog2(DEPTH):0] kill_hits;
`endif

  assign draining    = (state == ARB_DRAIN);
  assign wb_stall_o  = draining;
  assign mdu_ready_o = !fifo_full;
  assign mdu_entry   = '{rd: mdu_rd_i, data: mdu_data_i};

  assign wb_grant   = !draining && wb_we_i && (wb_rd_i != '0);
  assign mdu_push   = mdu_valid_i && !fifo_full && (mdu_rd_i != '0);
  // An empty buffer lets a fresh MDU result go straight to the port when WB is idle.
  assign bypass     = mdu_push && fifo_empty && !wb_grant;
  assign fifo_push  = mdu_push && !bypass;
  assign fifo_pop   = !wb_grant && !fifo_empty;
  assign head_write = fifo_pop && head_valid;

  mdu_result_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .push       (fifo_push),
    .push_entry (mdu_entry),
    .pop        (fifo_pop),
    .kill       (wb_grant),
    .kill_rd    (wb_rd_i),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .head_valid (head_valid),
    .head_entry (head_entry),
    .live_after (live_after)
`ifdef WB_ARB_STATS_EN
    ,
    .kill_hits  (kill_hits)
`endif
  );

  always_comb begin
    if (fifo_empty || fifo_pop) begin
      wait_next = '0;
    end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
      wait_next = wait_cnt + WAIT_W'(1);
    end else begin
      wait_next = wait_cnt;
    end
  end

  // Only enter or stay in drain while something live remains to be written.
  always_comb begin
    state_next = state;
    case (state)
      ARB_NORMAL: begin
        if ((wait_cnt == WAIT_W'(MAX_WAIT) || fifo_full) && live_after) state_next = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        if (!live_after) state_next = ARB_NORMAL;
      end
      default: state_next = ARB_NORMAL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ARB_NORMAL;
      wait_cnt   <= '0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      rf_we_o  <= wb_grant || head_write || bypass;
      if (wb_grant) begin
        rf_waddr_o <= wb_rd_i;
        rf_wdata_o <= wb_data_i;
      end else if (head_write) begin
        rf_waddr_o <= head_entry.rd;
        rf_wdata_o <= head_entry.data;
      end else if (bypass) begin
        rf_waddr_o <= mdu_rd_i;
        rf_wdata_o <= mdu_data_i;
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
      kill_cnt_o  <= '0;
    end else begin
      stall_cnt_o <= stall_cnt_o + 32'(draining);
      kill_cnt_o  <= kill_cnt_o + 32'(kill_hits);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// Self-checking bench for rf_write_arbiter against a queue-based behavioural model.
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        mdu_valid_i;
  logic [4:0]  mdu_rd_i;
  logic [31:0] mdu_data_i;
  logic        mdu_ready_o;
  logic        wb_stall_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
`ifdef WB_ARB_STATS_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] kill_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wb_we_i     (wb_we_i),
    .wb_rd_i     (wb_rd_i),
    .wb_data_i   (wb_data_i),
    .mdu_valid_i (mdu_valid_i),
    .mdu_rd_i    (mdu_rd_i),
    .mdu_data_i  (mdu_data_i),
    .mdu_ready_o (mdu_ready_o),
    .wb_stall_o  (wb_stall_o),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o)
`ifdef WB_ARB_STATS_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .kill_cnt_o  (kill_cnt_o)
`endif
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t        mq[$];
  bit          m_drain;
  int          m_wait;
  logic        exp_ready, exp_stall, exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic        smp_ready, smp_stall;
  int          exp_stall_cnt, exp_kill_cnt;
  int          checks = 0;
  int          errors = 0;

  function automatic void model_reset();
    mq.delete();
    m_drain = 0; m_wait = 0;
    exp_we = 0; exp_waddr = '0; exp_wdata = '0;
    exp_stall_cnt = 0; exp_kill_cnt = 0;
  endfunction

  // One clock of the arbitration rules applied to an ordered list of pending results.
  function automatic void model_step(input logic we, input logic [4:0] rd, input logic [31:0] d,
                                     input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    int   old_size = mq.size();
    int   old_wait = m_wait;
    bit   popped   = 0;
    bit   live     = 0;
    bit   wb_ok    = !m_drain && we && (rd != 0);
    bit   push     = mv && (old_size < DEPTH) && (mrd != 0);
    ent_t e;
    exp_ready = (old_size < DEPTH);
    exp_stall = m_drain;
    if (m_drain) exp_stall_cnt++;
    exp_we = 0;
    if (wb_ok) begin
      exp_we = 1; exp_waddr = rd; exp_wdata = d;
      foreach (mq[i]) if (mq[i].live && mq[i].rd == rd) begin
        mq[i].live = 0;
        exp_kill_cnt++;
      end
    end else if (old_size > 0) begin
      e = mq.pop_front();
      popped = 1;
      if (e.live) begin exp_we = 1; exp_waddr = e.rd; exp_wdata = e.data; end
    end else if (push) begin
      exp_we = 1; exp_waddr = mrd; exp_wdata = md;
      push = 0;
    end
    if (push) mq.push_back('{mrd, md, 1'b1});
    m_wait = (old_size == 0 || popped) ? 0 : ((old_wait < MAX_WAIT) ? old_wait + 1 : MAX_WAIT);
    foreach (mq[i]) if (mq[i].live) live = 1;
    if (!m_drain) begin
      if ((old_wait == MAX_WAIT || old_size == DEPTH) && live) m_drain = 1;
    end else if (!live) begin
      m_drain = 0;
    end
  endfunction

  task automatic cycle(input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    wb_we_i = we; wb_rd_i = rd; wb_data_i = d;
    mdu_valid_i = mv; mdu_rd_i = mrd; mdu_data_i = md;
    #1;
    smp_ready = mdu_ready_o;
    smp_stall = wb_stall_o;
    model_step(we, rd, d, mv, mrd, md);
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0; mdu_valid_i = 0; mdu_rd_i = 0; mdu_data_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", rf_we_o); end
    checks++; if (rf_waddr_o !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", rf_waddr_o); end
    checks++; if (rf_wdata_o !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", rf_wdata_o); end
    checks++; if (wb_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", wb_stall_o); end
    checks++; if (mdu_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", mdu_ready_o); end
`ifdef WB_ARB_STATS_EN
    checks++; if (stall_cnt_o !== 32'd0 || kill_cnt_o !== 32'd0) begin
      errors++; $display("FAIL reset_stats got %0d/%0d want 0/0", stall_cnt_o, kill_cnt_o);
    end
`endif
    rst_ni = 1'b1;
  endtask

  task automatic test_wb_only();
    for (int c = 0; c < 2; c++) begin
      if (c == 0) cycle(1, 5'd5, 32'h1234_5678, 0, 5'd0, 32'd0);
      else        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      checks++;
      if (smp_ready !== exp_ready || smp_stall !== exp_stall || rf_we_o !== exp_we ||
          (exp_we && (rf_waddr_o !== exp_waddr || rf_wdata_o !== exp_wdata))) begin
        errors++;
        $display("FAIL wb_only c%0d ready %b/%b stall %b/%b we %b/%b addr %0d/%0d data %h/%h", c,
                 smp_ready, exp_ready, smp_stall, exp_stall, rf_we_o, exp_we, rf_waddr_o, exp_waddr, rf_wdata_o, exp_wdata);
      end
      if (c == 0) begin
        checks++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 32'h1234_5678 || smp_stall !== 1'b0) begin
          errors++;
          $display("FAIL wb_only_direct got we %b addr %0d data %h stall %b want 1 5 12345678 0",
                   rf_we_o, rf_waddr_o, rf_wdata_o, smp_stall);
        end
      end
    end
  endtask

  task automatic test_contention();
    bit ready_ok = 1;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) cycle(1, 5'd3, 32'h0000_0033, 1, 5'd7, 32'hAAAA_AAAA);
      else        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      if (smp_ready !== 1'b1) ready_ok = 0;
      checks++;
      if (smp_ready !== exp_ready || smp_stall !== exp_stall || rf_we_o !== exp_we ||
          (exp_we && (rf_waddr_o !== exp_waddr || rf_wdata_o !== exp_wdata))) begin
        errors++;
        $display("FAIL contention c%0d ready %b/%b stall %b/%b we %b/%b addr %0d/%0d data %h/%h", c,
                 smp_ready, exp_ready, smp_stall, exp_stall, rf_we_o, exp_we, rf_waddr_o, exp_waddr, rf_wdata_o, exp_wdata);
      end
      if (c == 1) begin
        checks++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd7 || rf_wdata_o !== 32'hAAAA_AAAA) begin
          errors++;
          $display("FAIL contention_rd7 got we %b addr %0d data %h want 1 7 aaaaaaaa", rf_we_o, rf_waddr_o, rf_wdata_o);
        end
      end
    end
    checks++; if (!ready_ok) begin errors++; $display("FAIL contention_ready got 0 want 1"); end
  endtask

  task automatic test_starvation();
    int stalls = 0;
    int seen9  = 0;
    for (int c = 0; c < 15; c++) begin
      if (c == 0) cycle(1, 5'd1, $urandom(), 1, 5'd9, 32'h0999_0999);
      else        cycle(1, 5'(1 + (c % 8)), $urandom(), 0, 5'd0, 32'd0);
      if (smp_stall === 1'b1) stalls++;
      if (rf_we_o === 1'b1 && rf_waddr_o === 5'd9 && rf_wdata_o === 32'h0999_0999) seen9++;
      checks++;
      if (smp_ready !== exp_ready || smp_stall !== exp_stall || rf_we_o !== exp_we ||
          (exp_we && (rf_waddr_o !== exp_waddr || rf_wdata_o !== exp_wdata))) begin
        errors++;
        $display("FAIL starvation c%0d ready %b/%b stall %b/%b we %b/%b addr %0d/%0d data %h/%h", c,
                 smp_ready, exp_ready, smp_stall, exp_stall, rf_we_o, exp_we, rf_waddr_o, exp_waddr, rf_wdata_o, exp_wdata);
      end
    end
    checks++; if (stalls != 1) begin errors++; $display("FAIL starvation_stalls got %0d want 1", stalls); end
    checks++; if (seen9 != 1) begin errors++; $display("FAIL starvation_rd9 got %0d writes want 1", seen9); end
  endtask

  task automatic test_full();
    int   stalls    = 0;
    bit   saw_full  = 0;
    logic [4:0] order[$];
    for (int c = 0; c < 14; c++) begin
      if (c < 4) cycle(1, 5'(1 + (c % 5)), $urandom(), 1, 5'(10 + c), 32'(32'hF000_0000 + c));
      else       cycle(1, 5'(1 + (c % 5)), $urandom(), 0, 5'd0, 32'd0);
      if (smp_stall === 1'b1) stalls++;
      if (smp_ready === 1'b0) saw_full = 1;
      if (rf_we_o === 1'b1 && rf_waddr_o >= 5'd10) order.push_back(rf_waddr_o);
      checks++;
      if (smp_ready !== exp_ready || smp_stall !== exp_stall || rf_we_o !== exp_we ||
          (exp_we && (rf_waddr_o !== exp_waddr || rf_wdata_o !== exp_wdata))) begin
        errors++;
        $display("FAIL full c%0d ready %b/%b stall %b/%b we %b/%b addr %0d/%0d data %h/%h", c,
                 smp_ready, exp_ready, smp_stall, exp_stall, rf_we_o, exp_we, rf_waddr_o, exp_waddr, rf_wdata_o, exp_wdata);
      end
    end
    checks++; if (!saw_full) begin errors++; $display("FAIL full_ready got never-low want low"); end
    checks++; if (stalls != 4) begin errors++; $display("FAIL full_stalls got %0d want 4", stalls); end
    checks++;
    if (order.size() != 4 || order[0] != 5'd10 || order[1] != 5'd11 || order[2] != 5'd12 || order[3] != 5'd13) begin
      errors++; $display("FAIL full_order got %p want 10 11 12 13", order);
    end
  endtask

  task automatic test_waw();
    logic [31:0] last4 = '0;
    int          stale = 0;
`ifdef WB_ARB_STATS_EN
    logic [31:0] k0 = kill_cnt_o;
`endif
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      cycle(1, 5'd2, 32'h2222_2222, 1, 5'd4, 32'hBBBB_BBBB);
      else if (c == 1) cycle(1, 5'd4, 32'hCCCC_CCCC, 0, 5'd0, 32'd0);
      else             cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      if (rf_we_o === 1'b1 && rf_waddr_o === 5'd4) begin
        last4 = rf_wdata_o;
        if (rf_wdata_o === 32'hBBBB_BBBB) stale++;
      end
      checks++;
      if (smp_ready !== exp_ready || smp_stall !== exp_stall || rf_we_o !== exp_we ||
          (exp_we && (rf_waddr_o !== exp_waddr || rf_wdata_o !== exp_wdata))) begin
        errors++;
        $display("FAIL waw c%0d ready %b/%b stall %b/%b we %b/%b addr %0d/%0d data %h/%h", c,
                 smp_ready, exp_ready, smp_stall, exp_stall, rf_we_o, exp_we, rf_waddr_o, exp_waddr, rf_wdata_o, exp_wdata);
      end
    end
    checks++; if (last4 !== 32'hCCCC_CCCC) begin errors++; $display("FAIL waw_reg4 got %h want cccccccc", last4); end
    checks++; if (stale != 0) begin errors++; $display("FAIL waw_stale got %0d writes want 0", stale); end
`ifdef WB_ARB_STATS_EN
    checks++; if (kill_cnt_o - k0 !== 32'd1) begin errors++; $display("FAIL waw_killcnt got %0d want 1", kill_cnt_o - k0); end
`endif
  endtask

  task automatic test_x0_reset();
    bit in_drain = 0;
    cycle(1, 5'd0, 32'hDEAD_BEEF, 0, 5'd0, 32'd0);
    checks++;
    if (rf_we_o !== 1'b0 || exp_we !== 1'b0) begin
      errors++; $display("FAIL x0_write got we %b want 0", rf_we_o);
    end
    for (int c = 0; c < 12 && !in_drain; c++) begin
      cycle(1, 5'(1 + (c % 3)), $urandom(), (c < 4), 5'(20 + c), $urandom());
      if (wb_stall_o === 1'b1) in_drain = 1;
    end
    checks++; if (!in_drain) begin errors++; $display("FAIL x0_drain_entry got no stall want stall within 12 cycles"); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (rf_we_o !== 1'b0 || rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'd0 || wb_stall_o !== 1'b0 || mdu_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got we %b addr %0d data %h stall %b ready %b want 0 0 0 0 1",
               rf_we_o, rf_waddr_o, rf_wdata_o, wb_stall_o, mdu_ready_o);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      if (c == 1) cycle(0, 5'd0, 32'd0, 1, 5'd6, 32'hEEEE_0006);
      else        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      checks++;
      if (smp_ready !== exp_ready || smp_stall !== exp_stall || rf_we_o !== exp_we ||
          (exp_we && (rf_waddr_o !== exp_waddr || rf_wdata_o !== exp_wdata))) begin
        errors++;
        $display("FAIL post_reset c%0d ready %b/%b stall %b/%b we %b/%b addr %0d/%0d data %h/%h", c,
                 smp_ready, exp_ready, smp_stall, exp_stall, rf_we_o, exp_we, rf_waddr_o, exp_waddr, rf_wdata_o, exp_wdata);
      end
      if (c == 1) begin
        checks++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd6 || rf_wdata_o !== 32'hEEEE_0006) begin
          errors++; $display("FAIL post_reset_bypass got we %b addr %0d data %h want 1 6 eeee0006", rf_we_o, rf_waddr_o, rf_wdata_o);
        end
      end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 400; c++) begin
      cycle(logic'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom(),
            logic'($urandom_range(0, 99) < 35), 5'($urandom_range(0, 7)), $urandom());
      checks++;
      if (smp_ready !== exp_ready || smp_stall !== exp_stall || rf_we_o !== exp_we ||
          (exp_we && (rf_waddr_o !== exp_waddr || rf_wdata_o !== exp_wdata))) begin
        errors++;
        if (bad < 10)
          $display("FAIL random c%0d ready %b/%b stall %b/%b we %b/%b addr %0d/%0d data %h/%h", c,
                   smp_ready, exp_ready, smp_stall, exp_stall, rf_we_o, exp_we, rf_waddr_o, exp_waddr, rf_wdata_o, exp_wdata);
        bad++;
      end
    end
`ifdef WB_ARB_STATS_EN
    checks++;
    if (stall_cnt_o !== 32'(exp_stall_cnt) || kill_cnt_o !== 32'(exp_kill_cnt)) begin
      errors++;
      $display("FAIL random_stats got %0d/%0d want %0d/%0d", stall_cnt_o, kill_cnt_o, exp_stall_cnt, exp_kill_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_contention();
    test_starvation();
    test_full();
    test_waw();
    test_x0_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
